// File: rtl/mcx_port_agent.sv
// mcx_port_agent: far-end agent for one MCX simple-I/O port, TX/RX FIFOs to a host
// Ports:
//   clk, nrst           clock (rising edge), asynchronous active-low reset
//   pin                 shared port pins; driven only while DRIVE and the MCX has released them
//   mcx_oe              1 = MCX is driving pin
//   tx_data/valid/ready host -> TX FIFO push handshake
//   rx_data/valid/pop   RX FIFO head and host pop
//   rx_overflow/ovf_clr sticky RX drop flag and its clear
//   tx_busy             TX state machine is not IDLE
module mcx_port_agent #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4,
   parameter int HOLD  = 4
) (
   input  logic             clk,
   input  logic             nrst,
   inout  wire  [WIDTH-1:0] pin,
   input  logic             mcx_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_pop,
   output logic             rx_overflow,
   input  logic             ovf_clr,
   output logic             tx_busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [HW-1:0] HMAX = HW'(HOLD - 1);
   typedef enum logic [1:0] {IDLE, DRIVE, PAUSE} state_t;
   state_t state, state_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic [WIDTH-1:0] tx_mem [DEPTH];
   logic [AW-1:0] tx_wp, tx_rp;
   logic [CW-1:0] tx_cnt;
   logic tx_push, tx_pop;
   logic [WIDTH-1:0] rx_mem [DEPTH];
   logic [AW-1:0] rx_wp, rx_rp;
   logic [CW-1:0] rx_cnt;
   logic last_oe;
   logic [WIDTH-1:0] last_val;
   logic cap, rx_do_pop, rx_full, rx_push, rx_drop;
   assign tx_ready = tx_cnt != FULL;
   assign tx_push  = tx_valid && tx_ready;
   assign tx_busy  = state != IDLE;
   // Gated directly by mcx_oe so the agent lets go in the same cycle the MCX takes the pins
   assign pin = (state == DRIVE && !mcx_oe) ? tx_mem[tx_rp] : {WIDTH{1'bz}};
   always_ff @(posedge clk)
      if (tx_push) tx_mem[tx_wp] <= tx_data;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_cnt <= '0;
         state  <= IDLE;
         hcnt   <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop) tx_rp <= tx_rp + 1'b1;
         tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
         state  <= state_n;
         hcnt   <= hcnt_n;
      end
   // hcnt counts remaining MCX-released cycles for the head value; it freezes across PAUSE
   always_comb begin
      state_n = state;
      hcnt_n  = hcnt;
      tx_pop  = 1'b0;
      case (state)
         IDLE:
            if (tx_cnt != '0) begin
               state_n = mcx_oe ? PAUSE : DRIVE;
               hcnt_n  = HMAX;
            end
         DRIVE:
            if (mcx_oe) state_n = PAUSE;
            else if (hcnt != '0) hcnt_n = hcnt - 1'b1;
            else begin
               tx_pop = 1'b1;
               if (tx_cnt > CW'(1)) hcnt_n = HMAX;
               else state_n = IDLE;
            end
         PAUSE:
            if (!mcx_oe) state_n = DRIVE;
         default: state_n = IDLE;
      endcase
   end
   // Capture on the first MCX-driven cycle and on every change after that
   assign cap       = mcx_oe && (!last_oe || pin != last_val);
   assign rx_valid  = rx_cnt != '0;
   assign rx_data   = rx_valid ? rx_mem[rx_rp] : '0;
   assign rx_do_pop = rx_pop && rx_valid;
   assign rx_full   = rx_cnt == FULL;
   assign rx_push   = cap && (!rx_full || rx_do_pop);
   assign rx_drop   = cap && rx_full && !rx_do_pop;
   always_ff @(posedge clk)
      if (rx_push) rx_mem[rx_wp] <= pin;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         rx_wp       <= '0;
         rx_rp       <= '0;
         rx_cnt      <= '0;
         last_oe     <= 1'b0;
         last_val    <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_do_pop) rx_rp <= rx_rp + 1'b1;
         rx_cnt  <= rx_cnt + CW'(rx_push) - CW'(rx_do_pop);
         last_oe <= mcx_oe;
         if (mcx_oe) last_val <= pin;
         rx_overflow <= rx_drop || (rx_overflow && !ovf_clr);
      end
endmodule

// File: tb/tb_mcx_port_agent.sv
// tb_mcx_port_agent: directed bench for mcx_port_agent; released pins read as 7'h7F through pullups
module tb_mcx_port_agent;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic mcx_oe = 1'b0;
   logic [6:0] mcx_val = '0;
   logic [6:0] tx_data = '0;
   logic tx_valid = 1'b0;
   logic tx_ready;
   logic [6:0] rx_data;
   logic rx_valid;
   logic rx_pop = 1'b0;
   logic rx_overflow;
   logic ovf_clr = 1'b0;
   logic tx_busy;
   wire [6:0] pin;
   int errors = 0;
   int checks = 0;
   localparam logic [6:0] REL = 7'h7F;
   always #5 clk = ~clk;
   assign pin = mcx_oe ? mcx_val : 7'bz;
   for (genvar g = 0; g < 7; g++) begin : g_pu
      pullup (pin[g]);
   end
   mcx_port_agent #(.WIDTH(7), .DEPTH(4), .HOLD(4)) dut (
      .clk(clk), .nrst(nrst), .pin(pin), .mcx_oe(mcx_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .rx_overflow(rx_overflow), .ovf_clr(ovf_clr), .tx_busy(tx_busy)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   initial begin
      tick;
      tick;
      chk("rst_pin", pin, REL);
      chk("rst_tx_ready", 7'(tx_ready), 7'd1);
      chk("rst_rx_valid", 7'(rx_valid), 7'd0);
      chk("rst_rx_data", rx_data, 7'd0);
      chk("rst_ovf", 7'(rx_overflow), 7'd0);
      chk("rst_busy", 7'(tx_busy), 7'd0);
      nrst = 1'b1;
      tick;
      tx_data = 7'd3;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      tick;
      chk("pre_rst_pin", pin, 7'd3);
      chk("pre_rst_busy", 7'(tx_busy), 7'd1);
      nrst = 1'b0;
      #1;
      chk("midrst_pin", pin, REL);
      chk("midrst_busy", 7'(tx_busy), 7'd0);
      chk("midrst_ready", 7'(tx_ready), 7'd1);
      nrst = 1'b1;
      tick;
      tick;
      chk("postrst_pin", pin, REL);
      chk("postrst_busy", 7'(tx_busy), 7'd0);
      tx_data = 7'd5;
      tx_valid = 1'b1;
      tick;
      chk("t2_idle_pin", pin, REL);
      tx_data = 7'h7D;
      tick;
      tx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t2_pin5", pin, 7'd5);
         tick;
      end
      for (int i = 0; i < 4; i++) begin
         chk("t2_pin_m3", pin, 7'h7D);
         chk("t2_busy", 7'(tx_busy), 7'd1);
         tick;
      end
      chk("t2_end_pin", pin, REL);
      chk("t2_end_busy", 7'(tx_busy), 7'd0);
      tx_data = 7'd10;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      tick;
      chk("t3_d1", pin, 7'd10);
      tick;
      chk("t3_d2", pin, 7'd10);
      tick;
      chk("t3_d3", pin, 7'd10);
      mcx_oe = 1'b1;
      mcx_val = 7'h2A;
      #1;
      chk("t3_release", pin, 7'h2A);
      tick;
      tick;
      tick;
      chk("t3_pause_pin", pin, 7'h2A);
      chk("t3_pause_busy", 7'(tx_busy), 7'd1);
      mcx_oe = 1'b0;
      #1;
      chk("t3_pause_z", pin, REL);
      tick;
      chk("t3_r1", pin, 7'd10);
      tick;
      chk("t3_r2", pin, 7'd10);
      tick;
      chk("t3_end_pin", pin, REL);
      chk("t3_end_busy", 7'(tx_busy), 7'd0);
      chk("t3_rx_valid", 7'(rx_valid), 7'd1);
      chk("t3_rx_data", rx_data, 7'h2A);
      rx_pop = 1'b1;
      tick;
      rx_pop = 1'b0;
      chk("t3_rx_empty", 7'(rx_valid), 7'd0);
      chk("t3_rx_zero", rx_data, 7'd0);
      mcx_oe = 1'b1;
      mcx_val = 7'd7;
      tick;
      tick;
      tick;
      mcx_val = 7'd12;
      tick;
      tick;
      mcx_val = 7'h40;
      tick;
      mcx_oe = 1'b0;
      tick;
      mcx_oe = 1'b1;
      mcx_val = 7'd12;
      tick;
      mcx_oe = 1'b0;
      chk("t4_ovf", 7'(rx_overflow), 7'd0);
      chk("t4_rx0", rx_data, 7'd7);
      rx_pop = 1'b1;
      tick;
      chk("t4_rx1", rx_data, 7'd12);
      tick;
      chk("t4_rx2", rx_data, 7'h40);
      tick;
      chk("t4_rx3", rx_data, 7'd12);
      tick;
      rx_pop = 1'b0;
      chk("t4_empty", 7'(rx_valid), 7'd0);
      mcx_oe = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         mcx_val = 7'(i);
         tick;
      end
      chk("t5_full_ovf", 7'(rx_overflow), 7'd0);
      mcx_val = 7'd5;
      tick;
      chk("t5_drop_ovf", 7'(rx_overflow), 7'd1);
      chk("t5_drop_head", rx_data, 7'd1);
      ovf_clr = 1'b1;
      tick;
      ovf_clr = 1'b0;
      chk("t5_clr", 7'(rx_overflow), 7'd0);
      mcx_val = 7'd6;
      rx_pop = 1'b1;
      tick;
      rx_pop = 1'b0;
      chk("t5_pushpop_ovf", 7'(rx_overflow), 7'd0);
      chk("t5_pushpop_head", rx_data, 7'd2);
      mcx_val = 7'd7;
      ovf_clr = 1'b1;
      tick;
      ovf_clr = 1'b0;
      chk("t5_set_wins", 7'(rx_overflow), 7'd1);
      ovf_clr = 1'b1;
      tick;
      ovf_clr = 1'b0;
      chk("t5_clr2", 7'(rx_overflow), 7'd0);
      mcx_oe = 1'b0;
      chk("t5_d0", rx_data, 7'd2);
      rx_pop = 1'b1;
      tick;
      chk("t5_d1", rx_data, 7'd3);
      tick;
      chk("t5_d2", rx_data, 7'd4);
      tick;
      chk("t5_d3", rx_data, 7'd6);
      tick;
      rx_pop = 1'b0;
      chk("t5_empty", 7'(rx_valid), 7'd0);
      tx_valid = 1'b1;
      tx_data = 7'd20;
      tick;
      tx_data = 7'd21;
      tick;
      tx_data = 7'd22;
      tick;
      tx_data = 7'd23;
      tick;
      chk("t6_full", 7'(tx_ready), 7'd0);
      tx_data = 7'd24;
      tick;
      chk("t6_full2", 7'(tx_ready), 7'd0);
      chk("t6_pin20", pin, 7'd20);
      tick;
      chk("t6_free", 7'(tx_ready), 7'd1);
      chk("t6_pin21", pin, 7'd21);
      tick;
      chk("t6_refull", 7'(tx_ready), 7'd0);
      tx_valid = 1'b0;
      tx_data = 7'd99;
      tick;
      tick;
      tick;
      chk("t6_pin22", pin, 7'd22);
      repeat (4) tick;
      chk("t6_pin23", pin, 7'd23);
      repeat (4) tick;
      chk("t6_pin24", pin, 7'd24);
      repeat (4) tick;
      chk("t6_end_pin", pin, REL);
      chk("t6_end_busy", 7'(tx_busy), 7'd0);
      chk("t6_end_ready", 7'(tx_ready), 7'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
